mean_square_acc: RTL

- Upstream feeder for the iterative square-root stage; the pair forms an RMS magnitude path.
- Accepts a stream of signed samples and squares each one with a sequential shift-add multiplier.
- Accumulates 2^LOG2N squares and presents the mean square on a valid/ready output port.
- Output width is 2*WIDTH, so the downstream square-root stage is instantiated with NBITS = 2*WIDTH.

---
 rtl/mean_square_acc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mean_square_acc.sv
// mean_square_acc: squares a stream of signed samples with a sequential
// shift-add multiplier, accumulates 2^LOG2N squares and presents the
// floor-truncated mean square on a valid/ready port. Feeds the iterative
// square-root stage (instantiate it with NBITS = 2*WIDTH) to form RMS.
module mean_square_acc #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + LOG2N;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC, SEND} state_t;

  // |s| always fits in WIDTH unsigned bits, including -2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] s);
    logic signed [WIDTH-1:0] neg;
    neg = -s;
    return s[WIDTH-1] ? neg : s;
  endfunction

  // Mean of N squares, floor-truncated; the sum never exceeds N * 2^(PW-2).
  function automatic logic [PW-1:0] floor_mean(input logic [AW-1:0] sum);
    return PW'(sum >> LOG2N);
  endfunction

  logic signed [WIDTH-1:0] sample;
  assign sample = in_data;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] mag_q,       mag_d;
  logic [PW-1:0]    prod_q,      prod_d;
  logic [CW-1:0]    bitcnt_q,    bitcnt_d;
  logic [AW-1:0]    acc_q,       acc_d;
  logic [LOG2N-1:0] cnt_q,       cnt_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_data_q,  out_data_d;

  logic             mag_bit;
  logic [PW-1:0]    partial;
  logic [AW-1:0]    sum_w;

  // Next-state and datapath: one multiplier bit per MUL cycle, LSB first.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    prod_d      = prod_q;
    bitcnt_d    = bitcnt_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    mag_bit = |(mag_q & (WIDTH'(1) << bitcnt_q));
    partial = {{WIDTH{1'b0}}, mag_q} << bitcnt_q;
    sum_w   = acc_q + AW'(prod_q);

    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          mag_d      = magnitude(sample);
          prod_d     = '0;
          bitcnt_d   = '0;
          in_ready_d = 1'b0;
          state_d    = MUL;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      MUL: begin
        if (mag_bit) begin
          prod_d = prod_q + partial;
        end
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == CW'(WIDTH - 1)) begin
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum_w;
        cnt_d = cnt_q + LOG2N'(1);
        if (cnt_q == {LOG2N{1'b1}}) begin
          out_data_d  = floor_mean(sum_w);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any partial accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      prod_q      <= '0;
      bitcnt_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      prod_q      <= prod_d;
      bitcnt_q    <= bitcnt_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
